// File: rtl/rot_ctrl.sv
// rot_ctrl: sequencing controller for the image rotation engine.
// Walks the source image one 8-bit pixel at a time in raster order. For each
// pixel it reads the source byte over the DMA read channel, then writes it to
// the rotated destination address over the DMA write channel.
//
// Ports:
//   I_PCLK / I_PRESET_N        clock (rising edge) / async active-low reset
//   I_DMA_SRC_IMG/_DST_IMG     source / destination base byte addresses
//   I_ROT_IMG_H/_W             source height / width in pixels
//   I_ROT_IMG_MODE/_DIR        quarter-turns and direction (0 cw, 1 ccw)
//   I_CTRL_START               rising edge starts a job
//   I_CTRL_RESET               synchronous soft reset (level)
//   I_CTRL_INTR_MASK/_CLEAR    interrupt mask / pending clear
//   O_ROT_IMG_NEW_H/_W         rotated dimensions
//   O_CTRL_BUSY, O_INTR        job in progress / masked completion interrupt
//   O_RD_* / I_RD_*            DMA read request channel
//   O_WR_* / I_WR_*            DMA write request channel
module rot_ctrl (
  input  logic        I_PCLK,
  input  logic        I_PRESET_N,
  input  logic [31:0] I_DMA_SRC_IMG,
  input  logic [31:0] I_DMA_DST_IMG,
  input  logic [15:0] I_ROT_IMG_H,
  input  logic [15:0] I_ROT_IMG_W,
  input  logic [1:0]  I_ROT_IMG_MODE,
  input  logic        I_ROT_IMG_DIR,
  input  logic        I_CTRL_START,
  input  logic        I_CTRL_RESET,
  input  logic        I_CTRL_INTR_MASK,
  input  logic        I_CTRL_INTR_CLEAR,
  output logic [15:0] O_ROT_IMG_NEW_H,
  output logic [15:0] O_ROT_IMG_NEW_W,
  output logic        O_CTRL_BUSY,
  output logic        O_INTR,
  output logic        O_RD_REQ,
  output logic [31:0] O_RD_ADDR,
  input  logic        I_RD_ACK,
  input  logic [7:0]  I_RD_DATA,
  output logic        O_WR_REQ,
  output logic [31:0] O_WR_ADDR,
  output logic [7:0]  O_WR_DATA,
  input  logic        I_WR_ACK
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] h_q, h_d, w_q, w_d;
  logic [1:0]  r_q, r_d;
  logic [15:0] new_h_q, new_h_d, new_w_q, new_w_d;
  logic        busy_q, busy_d;
  logic        pend_q, pend_d;
  logic        intr_q, intr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        start_q;

  logic        start_rise;
  logic [1:0]  rot_in;
  logic        last_x, last_y;
  logic [31:0] xw, yw, hw, ww, h_m1_y, w_m1_x, dst_idx, rd_addr;

  assign start_rise = I_CTRL_START & ~start_q;
  // Counter-clockwise quarter-turns map to (4 - MODE) mod 4 clockwise turns.
  assign rot_in     = I_ROT_IMG_DIR ? (2'd0 - I_ROT_IMG_MODE) : I_ROT_IMG_MODE;
  assign last_x     = (x_q == w_q - 16'd1);
  assign last_y     = (y_q == h_q - 16'd1);

  assign xw     = {16'd0, x_q};
  assign yw     = {16'd0, y_q};
  assign hw     = {16'd0, h_q};
  assign ww     = {16'd0, w_q};
  assign h_m1_y = hw - 32'd1 - yw;
  assign w_m1_x = ww - 32'd1 - xw;
  assign rd_addr = src_q + yw * ww + xw;

  always_comb begin
    dst_idx = yw * ww + xw;
    case (r_q)
      2'd0:    dst_idx = yw * ww + xw;
      2'd1:    dst_idx = xw * hw + h_m1_y;
      2'd2:    dst_idx = h_m1_y * ww + w_m1_x;
      default: dst_idx = w_m1_x * hw + yw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    src_d   = src_q;
    dst_d   = dst_q;
    h_d     = h_q;
    w_d     = w_q;
    r_d     = r_q;
    new_h_d = new_h_q;
    new_w_d = new_w_q;
    busy_d  = busy_q;
    wdata_d = wdata_q;
    // Completion set takes priority over a concurrent clear.
    pend_d  = (state_q == StDone) | (pend_q & ~I_CTRL_INTR_CLEAR);
    intr_d  = pend_q & ~I_CTRL_INTR_MASK;

    case (state_q)
      StIdle: begin
        if (start_rise) begin
          src_d  = I_DMA_SRC_IMG;
          dst_d  = I_DMA_DST_IMG;
          h_d    = I_ROT_IMG_H;
          w_d    = I_ROT_IMG_W;
          r_d    = rot_in;
          busy_d = 1'b1;
          x_d    = '0;
          y_d    = '0;
          if (rot_in[0]) begin
            new_w_d = I_ROT_IMG_H;
            new_h_d = I_ROT_IMG_W;
          end else begin
            new_w_d = I_ROT_IMG_W;
            new_h_d = I_ROT_IMG_H;
          end
          state_d = ((I_ROT_IMG_W == 16'd0) || (I_ROT_IMG_H == 16'd0)) ? StDone : StRd;
        end
      end
      StRd: begin
        if (I_RD_ACK) begin
          wdata_d = I_RD_DATA;
          state_d = StWr;
        end
      end
      StWr: begin
        if (I_WR_ACK) begin
          if (last_x) begin
            x_d     = '0;
            y_d     = y_q + 16'd1;
            state_d = last_y ? StDone : StRd;
          end else begin
            x_d     = x_q + 16'd1;
            state_d = StRd;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Soft reset clears everything except the start-edge history.
    if (I_CTRL_RESET) begin
      state_d = StIdle;
      x_d     = '0;
      y_d     = '0;
      src_d   = '0;
      dst_d   = '0;
      h_d     = '0;
      w_d     = '0;
      r_d     = '0;
      new_h_d = '0;
      new_w_d = '0;
      busy_d  = 1'b0;
      wdata_d = '0;
      pend_d  = 1'b0;
      intr_d  = 1'b0;
    end
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      h_q     <= '0;
      w_q     <= '0;
      r_q     <= '0;
      new_h_q <= '0;
      new_w_q <= '0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      intr_q  <= 1'b0;
      wdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      h_q     <= h_d;
      w_q     <= w_d;
      r_q     <= r_d;
      new_h_q <= new_h_d;
      new_w_q <= new_w_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      intr_q  <= intr_d;
      wdata_q <= wdata_d;
      start_q <= I_CTRL_START;
    end
  end

  assign O_ROT_IMG_NEW_H = new_h_q;
  assign O_ROT_IMG_NEW_W = new_w_q;
  assign O_CTRL_BUSY     = busy_q;
  assign O_INTR          = intr_q;
  assign O_RD_REQ        = (state_q == StRd);
  assign O_WR_REQ        = (state_q == StWr);
  // Addresses are only driven while their request is up; zero otherwise.
  assign O_RD_ADDR       = (state_q == StRd) ? rd_addr : 32'd0;
  assign O_WR_ADDR       = (state_q == StWr) ? (dst_q + dst_idx) : 32'd0;
  assign O_WR_DATA       = wdata_q;

endmodule

// File: tb/tb_rot_ctrl.sv
// tb_rot_ctrl: directed, table-driven bench for rot_ctrl with a DMA responder
// that models optional ACK stalls and spurious ACKs while REQ is low.
module tb_rot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src, dst;
  logic [15:0] img_h, img_w;
  logic [1:0]  mode;
  logic        dir, start, soft_rst, mask, intr_clr;
  logic [15:0] new_h, new_w;
  logic        busy, intr;
  logic        rd_req, rd_ack, wr_req, wr_ack;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  rd_data, wr_data;

  always #5 clk = ~clk;

  rot_ctrl u_dut (
    .I_PCLK            (clk),
    .I_PRESET_N        (rst_n),
    .I_DMA_SRC_IMG     (src),
    .I_DMA_DST_IMG     (dst),
    .I_ROT_IMG_H       (img_h),
    .I_ROT_IMG_W       (img_w),
    .I_ROT_IMG_MODE    (mode),
    .I_ROT_IMG_DIR     (dir),
    .I_CTRL_START      (start),
    .I_CTRL_RESET      (soft_rst),
    .I_CTRL_INTR_MASK  (mask),
    .I_CTRL_INTR_CLEAR (intr_clr),
    .O_ROT_IMG_NEW_H   (new_h),
    .O_ROT_IMG_NEW_W   (new_w),
    .O_CTRL_BUSY       (busy),
    .O_INTR            (intr),
    .O_RD_REQ          (rd_req),
    .O_RD_ADDR         (rd_addr),
    .I_RD_ACK          (rd_ack),
    .I_RD_DATA         (rd_data),
    .O_WR_REQ          (wr_req),
    .O_WR_ADDR         (wr_addr),
    .O_WR_DATA         (wr_data),
    .I_WR_ACK          (wr_ack)
  );

  int errors = 0;
  int checks = 0;

  // Responder / monitor state (written only by the negedge process).
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [7:0]  wdata_log[$];
  int          busy_cnt = 0;
  int          req_cnt  = 0;
  int          stab_err = 0;
  int          rd_wait = 0, rd_dly = 0, wr_wait = 0, wr_dly = 0;
  logic        prev_rd_req = 1'b0, prev_rd_ack = 1'b0;
  logic        prev_wr_req = 1'b0, prev_wr_ack = 1'b0;
  logic [31:0] prev_rd_addr = '0, prev_wr_addr = '0;
  logic [7:0]  prev_wr_data = '0;
  int          stall_max = 0;
  logic        spurious = 1'b0;

  // Job bookkeeping (written only by the main process).
  int rd_base, wr_base, busy_base, req_base;

  initial begin
    rd_ack  = 1'b0;
    wr_ack  = 1'b0;
    rd_data = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_ack = 1'b0;
      wr_ack = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (rd_req || wr_req) req_cnt++;
      if (prev_rd_req && !prev_rd_ack && rd_req && (rd_addr !== prev_rd_addr)) stab_err++;
      if (prev_wr_req && !prev_wr_ack && wr_req &&
          ((wr_addr !== prev_wr_addr) || (wr_data !== prev_wr_data))) stab_err++;
      if (rd_req) begin
        if (rd_wait >= rd_dly) begin
          rd_ack  = 1'b1;
          rd_data = rd_addr[7:0] ^ 8'h5a;
          rd_log.push_back(rd_addr);
          rd_wait = 0;
          rd_dly  = $urandom_range(0, stall_max);
        end else begin
          rd_ack = 1'b0;
          rd_wait++;
        end
      end else begin
        rd_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (wr_req) begin
        if (wr_wait >= wr_dly) begin
          wr_ack = 1'b1;
          wr_log.push_back(wr_addr);
          wdata_log.push_back(wr_data);
          wr_wait = 0;
          wr_dly  = $urandom_range(0, stall_max);
        end else begin
          wr_ack = 1'b0;
          wr_wait++;
        end
      end else begin
        wr_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      prev_rd_req  = rd_req;
      prev_rd_ack  = rd_ack;
      prev_rd_addr = rd_addr;
      prev_wr_req  = wr_req;
      prev_wr_ack  = wr_ack;
      prev_wr_addr = wr_addr;
      prev_wr_data = wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    rd_base   = rd_log.size();
    wr_base   = wr_log.size();
    busy_base = busy_cnt;
    req_base  = req_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 32'(busy), 32'd0);
  endtask

  task automatic run_job(input logic [15:0] w, input logic [15:0] h, input logic [1:0] m,
                         input logic d, input string tag, output int cyc);
    img_w = w;
    img_h = h;
    mode  = m;
    dir   = d;
    snap();
    pulse_start();
    wait_idle(tag);
    cyc = busy_cnt - busy_base;
  endtask

  // Six 3x2 pixels: reads must be SRC+k in raster order; write k must land on
  // DST + ord nibble k and carry the byte the responder returned for read k.
  task automatic check_pixels(input string tag, input logic [23:0] ord);
    int nw = wr_log.size() - wr_base;
    int nr = rd_log.size() - rd_base;
    check({tag, "_wr_count"}, 32'(nw), 32'd6);
    check({tag, "_rd_count"}, 32'(nr), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < nr)
        check($sformatf("%s_rd_addr%0d", tag, k), rd_log[rd_base + k], 32'h1000 + 32'(k));
      if (k < nw) begin
        check($sformatf("%s_wr_addr%0d", tag, k), wr_log[wr_base + k],
              32'h2000 + 32'(ord[23 - 4 * k -: 4]));
        check($sformatf("%s_wr_data%0d", tag, k), 32'(wdata_log[wr_base + k]),
              32'(8'(k) ^ 8'h5a));
      end
    end
  endtask

  task automatic clear_intr(input string tag);
    @(negedge clk) intr_clr = 1'b1;
    @(negedge clk) intr_clr = 1'b0;
    @(negedge clk);
    check({tag, "_intr_cleared"}, 32'(intr), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        dir;
    logic [15:0] nw;
    logic [15:0] nh;
    logic [23:0] ord;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc;
    int n;
    vecs[0] = '{2'd0, 1'b0, 16'd3, 16'd2, 24'h012345};  // copy
    vecs[1] = '{2'd1, 1'b0, 16'd2, 16'd3, 24'h135024};  // 90 cw
    vecs[2] = '{2'd1, 1'b1, 16'd2, 16'd3, 24'h420531};  // 90 ccw == 270 cw
    vecs[3] = '{2'd3, 1'b0, 16'd2, 16'd3, 24'h420531};  // 270 cw
    vecs[4] = '{2'd2, 1'b1, 16'd3, 16'd2, 24'h543210};  // 180
    vecs[5] = '{2'd3, 1'b1, 16'd2, 16'd3, 24'h135024};  // 270 ccw == 90 cw

    rst_n = 1'b0; src = 32'h1000; dst = 32'h2000; img_h = 16'd2; img_w = 16'd3;
    mode = 2'd0; dir = 1'b0; start = 1'b0; soft_rst = 1'b0; mask = 1'b0; intr_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_new_h", 32'(new_h), 32'd0);
    check("rst_new_w", 32'(new_w), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Rotation table, zero-wait ACK.
    for (int i = 0; i < 6; i++) begin
      string tag = $sformatf("vec%0d", i);
      run_job(16'd3, 16'd2, vecs[i].mode, vecs[i].dir, tag, cyc);
      check({tag, "_new_w"}, 32'(new_w), 32'(vecs[i].nw));
      check({tag, "_new_h"}, 32'(new_h), 32'(vecs[i].nh));
      check({tag, "_busy_cycles"}, 32'(cyc), 32'd13);
      check_pixels(tag, vecs[i].ord);
      @(negedge clk);
      check({tag, "_intr"}, 32'(intr), 32'd1);
      clear_intr(tag);
    end

    // Stalled handshakes, spurious ACKs, restart and config change while busy.
    stall_max = 3;
    spurious  = 1'b1;
    img_w = 16'd3; img_h = 16'd2; mode = 2'd1; dir = 1'b0;
    snap();
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1; img_w = 16'd5; mode = 2'd0; src = 32'h4000;
    @(negedge clk) start = 1'b0;
    wait_idle("stall");
    cyc = busy_cnt - busy_base;
    src = 32'h1000;
    stall_max = 0;
    spurious  = 1'b0;
    check("stall_stable", 32'(stab_err), 32'd0);
    check("stall_longer", 32'(cyc >= 13), 32'd1);
    check("stall_new_w", 32'(new_w), 32'd2);
    check_pixels("stall", 24'h135024);
    repeat (3) @(negedge clk);
    check("stall_no_restart", 32'(busy), 32'd0);
    clear_intr("stall");

    // Masked completion, then unmask.
    mask = 1'b1;
    run_job(16'd3, 16'd2, 2'd0, 1'b0, "mask", cyc);
    repeat (2) @(negedge clk);
    check("mask_intr_low", 32'(intr), 32'd0);
    mask = 1'b0;
    repeat (2) @(negedge clk);
    check("unmask_intr_high", 32'(intr), 32'd1);
    clear_intr("mask");

    // CLEAR asserted in the DONE cycle: set wins.
    snap();
    pulse_start();
    n = 0;
    while (!(busy && !rd_req && !wr_req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(busy && !rd_req && !wr_req), 32'd1);
    intr_clr = 1'b1;
    @(negedge clk) intr_clr = 1'b0;
    check("done_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    check("set_beats_clear", 32'(intr), 32'd1);
    clear_intr("setclr");

    // Empty image: one DONE cycle, no requests, interrupt still raised.
    run_job(16'd0, 16'd2, 2'd0, 1'b0, "w0", cyc);
    check("w0_busy_cycles", 32'(cyc), 32'd1);
    check("w0_no_req", 32'(req_cnt - req_base), 32'd0);
    check("w0_new_h", 32'(new_h), 32'd2);
    @(negedge clk);
    check("w0_intr", 32'(intr), 32'd1);

    // Soft reset after three pixels.
    img_w = 16'd3; img_h = 16'd2; mode = 2'd0; dir = 1'b0;
    snap();
    pulse_start();
    n = 0;
    while ((wr_log.size() - wr_base) < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk) soft_rst = 1'b1;
    @(negedge clk);
    check("srst_busy", 32'(busy), 32'd0);
    check("srst_rd_req", 32'(rd_req), 32'd0);
    check("srst_wr_req", 32'(wr_req), 32'd0);
    check("srst_new_w", 32'(new_w), 32'd0);
    soft_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("srst_no_intr", 32'(intr), 32'd0);
    check("srst_stays_idle", 32'(busy), 32'd0);
    run_job(16'd3, 16'd2, 2'd0, 1'b0, "post_srst", cyc);
    check("post_srst_cycles", 32'(cyc), 32'd13);
    check_pixels("post_srst", 24'h012345);
    @(negedge clk);
    check("post_srst_intr", 32'(intr), 32'd1);

    // Async reset while a write request is up.
    snap();
    pulse_start();
    n = 0;
    while (!wr_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("arst_in_wr", 32'(wr_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_intr", 32'(intr), 32'd0);
    check("arst_wr_req", 32'(wr_req), 32'd0);
    check("arst_wr_addr", wr_addr, 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_new_w", 32'(new_w), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_idle", 32'(rd_req | wr_req | busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rot_ctrl.md
# rot_ctrl

Sequencing controller for the image rotation engine: takes the configuration held in the APB register block (source/destination base, image size, mode, direction, start/reset/interrupt controls) and walks the source image one 8-bit pixel at a time. For each pixel it issues a DMA read, then a DMA write to the rotated destination address. It reports busy, the rotated dimensions and a maskable completion interrupt back to the register block.

## Interface
- No parameters; pixel = 8 bits, byte-addressed, 32-bit addresses.
- I_PCLK in 1 — sole clock, rising edge.
- I_PRESET_N in 1 — asynchronous, active-low reset.
- I_DMA_SRC_IMG in 32 — source image base byte address.
- I_DMA_DST_IMG in 32 — destination image base byte address.
- I_ROT_IMG_H / I_ROT_IMG_W in 16 each — source height / width in pixels.
- I_ROT_IMG_MODE in 2 — rotation quarter-turns: 0=0°, 1=90°, 2=180°, 3=270°.
- I_ROT_IMG_DIR in 1 — 0 clockwise, 1 counter-clockwise.
- I_CTRL_START in 1 — level from register; rising edge starts a job.
- I_CTRL_RESET in 1 — synchronous soft reset, level.
- I_CTRL_INTR_MASK in 1 — 1 masks O_INTR.
- I_CTRL_INTR_CLEAR in 1 — clears interrupt pending, level.
- O_ROT_IMG_NEW_H / O_ROT_IMG_NEW_W out 16 each — rotated dimensions.
- O_CTRL_BUSY out 1 — job in progress.
- O_INTR out 1 — pending & ~mask.
- O_RD_REQ out 1, O_RD_ADDR out 32, I_RD_ACK in 1, I_RD_DATA in 8 — DMA read channel.
- O_WR_REQ out 1, O_WR_ADDR out 32, O_WR_DATA out 8, I_WR_ACK in 1 — DMA write channel.

## Operation
- Reset (async or soft): state IDLE; all outputs 0; x, y, pending, and the latched config cleared. The start-edge register is cleared by async reset only.
- Effective rotation: r = MODE if DIR=0, else (4−MODE) mod 4.
- Rotated dimensions: r even → NEW_W=W, NEW_H=H; r odd → NEW_W=H, NEW_H=W.
- Job acceptance (in IDLE):
  - On a START rising edge, latch SRC, DST, H, W and r.
  - Update NEW_H/NEW_W and set BUSY.
  - Clear x and y.
  - If W=0 or H=0, go to DONE; otherwise go to RD.
- Config changes while BUSY have no effect. A START edge while BUSY is ignored.
- Source index: (x, y), with x in [0,W) and y in [0,H). O_RD_ADDR = SRC + y·W + x.
- Destination index (O_WR_ADDR = DST + idx):
  - r=0: y·W + x
  - r=1: x·H + (H−1−y)
  - r=2: (H−1−y)·W + (W−1−x)
  - r=3: (W−1−x)·H + y
- Arithmetic is 32-bit unsigned; sums wrap modulo 2^32.
- States:
  - IDLE.
  - RD: RD_REQ=1. When I_RD_ACK=1, capture I_RD_DATA into O_WR_DATA and go to WR.
  - WR: WR_REQ=1. When I_WR_ACK=1, advance the pixel. If x=W−1, set x=0 and y+1; otherwise x+1. If that was the last pixel (x=W−1, y=H−1), go to DONE; else go to RD.
  - DONE: one cycle. Set pending, clear BUSY, go to IDLE.
- Handshake rules:
  - REQ and its ADDR/DATA are held stable until the matching ACK is sampled high.
  - REQ drops the cycle after ACK.
  - ACK when REQ is low is ignored.
- Interrupt pending: sticky. Cleared by INTR_CLEAR. If set (DONE) and clear occur in the same cycle, set wins.
- O_INTR is registered from pending & ~MASK.
- Soft reset I_CTRL_RESET=1 mid-job: abort at the next edge to IDLE, with REQs dropped, BUSY=0 and no interrupt.

## Timing
- START edge sampled in cycle N → BUSY=1 and RD_REQ=1 from cycle N+1.
- With zero-wait ACK (ACK in the same cycle REQ is seen): each pixel takes 2 cycles.
- Job length with zero-wait ACK: 2·W·H cycles in RD/WR, plus 1 DONE cycle.
- BUSY falls and pending rises at the edge leaving DONE. O_INTR follows 1 cycle later.
- Each ACK wait cycle extends the pixel by one cycle. There is no timeout.
- W=0 or H=0: BUSY is high for exactly 1 cycle (DONE); no REQ is issued; pending is still set.

## Test plan
- Copy: W=3, H=2, MODE=0, SRC=0x1000, DST=0x2000, zero-wait ACK.
  - Expect 6 reads at 0x1000..0x1005 and writes to 0x2000..0x2005 with matching data.
  - BUSY high for 13 cycles; NEW 3×2.
- 90° CW: W=3, H=2, MODE=1, DIR=0.
  - Pixel (0,0) writes 0x2001; (2,1) writes 0x2004; full destination order is 1,3,5,0,2,4.
  - NEW_W=2, NEW_H=3.
- 90° CCW equivalence: MODE=1, DIR=1 produces the same addresses as MODE=3, DIR=0.
  - Pixel (0,0) writes 0x2004.
  - 180°: pixel (0,0) writes 0x2005.
- Handshake stalls: random 0–3 cycle ACK delays.
  - ADDR/DATA stable while REQ is high; no duplicate or missing pixel.
  - Restarting with START during BUSY changes nothing.
- Interrupt:
  - MASK=1 at completion → O_INTR=0. Unmasking then gives O_INTR=1.
  - CLEAR in the same cycle as DONE leaves pending=1. CLEAR later → O_INTR=0.
  - W=0 → no REQ, 1-cycle BUSY, pending=1.
- Resets:
  - Soft reset after 3 pixels → IDLE next cycle, REQs low, no interrupt; a new START runs a full job.
  - Async reset mid-WR → all outputs 0 immediately.
